// File: rtl/hsv_to_rgb_seq_pkg.sv
// Shared definitions for the HSV-to-RGB converter: FSM state encoding, hue constants
// and the rounding divide-by-255 helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package hsv_to_rgb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_P  = 3'd1,
    MUL_SF = 3'd2,
    MUL_SG = 3'd3,
    MUL_Q  = 3'd4,
    MUL_T  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam int HUE_SECTOR_SIZE = 256;
  localparam int HUE_MAX         = 1536;

  // round(x/255) for x in 0..65025 using only adds and shifts.
  // x+128 and the correction term both stay below 2^16 for that input range.
  function automatic logic [7:0] div255(input logic [15:0] x);
    logic [15:0] y;
    y = x + 16'd128;
    y = y + (y >> 8);
    return y[15:8];
  endfunction

endpackage

// File: rtl/hsv_to_rgb_seq_mul8x8_u.sv
// Combinational 8x8 unsigned multiplier, shared by all product steps of the converter.
// Latency: 0 cycles (pure combinational). Backpressure: none, operands are muxed by the caller.
// Ports: a, b = 8-bit operands; p = 16-bit product.
module mul8x8_u (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = 16'(a) * 16'(b);

endmodule

// File: rtl/hsv_to_rgb_seq.sv
// Iterative HSV-to-RGB converter: five time-multiplexed multiplies on one 8x8 multiplier.
// Latency: out_valid rises 6 cycles after the input handshake; one pixel in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + h,s,v input handshake;
//        out_valid/out_ready + r,g,b output handshake.
module hsv_to_rgb_seq
  import hsv_to_rgb_seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int HW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [HW-1:0] h,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  r,
  output logic [W-1:0]  g,
  output logic [W-1:0]  b
);

  localparam int            FW   = $clog2(HUE_SECTOR_SIZE);
  localparam logic [2:0]    NSEC = 3'(HUE_MAX / HUE_SECTOR_SIZE);
  localparam logic [W-1:0]  VMAX = '1;

  state_t         state, nxt;
  logic [2:0]     sec_in, sec_n, sec_q;
  logic [W-1:0]   f_q, s_q, v_q;
  logic [W-1:0]   p_q, sf_q, sg_q, q_q;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   r_n, g_n, b_n;

  // Hues past the last sector wrap by one full turn; only the sector field changes.
  assign sec_in = h[HW-1:FW];
  assign sec_n  = (sec_in >= NSEC) ? sec_in - NSEC : sec_in;

  mul8x8_u u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  assign quo = div255(prod);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  nxt = MUL_P;
      MUL_P:   nxt = MUL_SF;
      MUL_SF:  nxt = MUL_SG;
      MUL_SG:  nxt = MUL_Q;
      MUL_Q:   nxt = MUL_T;
      MUL_T:   nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output logic: handshake flags come straight from the state register, so a new
  // pixel can be taken only in the cycle after the DONE handshake.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    unique case (state)
      IDLE:    in_ready = ~rst;
      MUL_P:   begin mul_a = v_q; mul_b = VMAX - s_q;  end
      MUL_SF:  begin mul_a = s_q; mul_b = f_q;         end
      MUL_SG:  begin mul_a = s_q; mul_b = VMAX - f_q;  end
      MUL_Q:   begin mul_a = v_q; mul_b = VMAX - sf_q; end
      MUL_T:   begin mul_a = v_q; mul_b = VMAX - sg_q; end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Sector mapping, evaluated during MUL_T where the live quotient is t.
  always_comb begin
    r_n = v_q;
    g_n = quo;
    b_n = p_q;
    case (sec_q)
      3'd1:    begin r_n = q_q; g_n = v_q; b_n = p_q; end
      3'd2:    begin r_n = p_q; g_n = v_q; b_n = quo; end
      3'd3:    begin r_n = p_q; g_n = q_q; b_n = v_q; end
      3'd4:    begin r_n = quo; g_n = p_q; b_n = v_q; end
      3'd5:    begin r_n = v_q; g_n = p_q; b_n = q_q; end
      default: begin r_n = v_q; g_n = quo; b_n = p_q; end
    endcase
  end

  // Datapath: capture operands in IDLE, latch one quotient per multiply state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q <= '0;
      f_q   <= '0;
      s_q   <= '0;
      v_q   <= '0;
      p_q   <= '0;
      sf_q  <= '0;
      sg_q  <= '0;
      q_q   <= '0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sec_q <= sec_n;
            f_q   <= h[FW-1:0];
            s_q   <= s;
            v_q   <= v;
          end
        end
        MUL_P:  p_q  <= quo;
        MUL_SF: sf_q <= quo;
        MUL_SG: sg_q <= quo;
        MUL_Q:  q_q  <= quo;
        MUL_T: begin
          r <= r_n;
          g <= g_n;
          b <= b_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hsv_to_rgb_seq.md
Name: hsv_to_rgb_seq

Overview:
Converts one HSV pixel back to RGB. It is the inverse path of the RGB-to-HSV front end that computes max, min and the channel differences. Multi-cycle and iterative: one shared 8x8 multiplier is time-multiplexed through an FSM. Valid/ready handshakes on both sides; one pixel in flight at a time.

Parameters:
W, 8, channel width for S, V, R, G, B (design verified only at 8)
HW, 11, hue width; hue range is 0..1535, i.e. 6 sectors of 256

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel
h  in  HW  hue; [10:8] = sector, [7:0] = fraction f
s  in  W  saturation, 0..255
v  in  W  value, 0..255
out_valid  out  1  r/g/b valid
out_ready  in  1  downstream accepts the result
r  out  W  red
g  out  W  green
b  out  W  blue

Behaviour:
- Reset values: in_ready=0 during the rst cycle, then 1 in IDLE; out_valid=0; r=g=b=0; FSM=IDLE. Reset mid-operation aborts the pixel; no output is produced.
- Hue normalisation: for h>=1536 the block uses h-1536, so sector 6 maps to sector 0 and sector 7 maps to sector 1, with f unchanged.
- Div255(x): (x + 128 + ((x+128)>>8)) >> 8. This is exact round(x/255) for x in 0..65025. Implemented with adds and shifts only.
- Math:
  - p = Div255(V*(255-S))
  - sf = Div255(S*f)
  - sg = Div255(S*(255-f))
  - q = Div255(V*(255-sf))
  - t = Div255(V*(255-sg))
- Sector output mapping (r,g,b):
  - 0: (V,t,p)
  - 1: (q,V,p)
  - 2: (p,V,t)
  - 3: (p,q,V)
  - 4: (t,p,V)
  - 5: (V,p,q)
- FSM: IDLE -> MUL_P -> MUL_SF -> MUL_SG -> MUL_Q -> MUL_T -> DONE -> IDLE. One multiply per state.
  - IDLE: in_ready=1. On in_valid, capture h, s, v into registers and go to MUL_P.
  - MUL_P .. MUL_T: in_ready=0. Each state issues one product and latches the corresponding Div255 result. MUL_Q and MUL_T consume the sf and sg latched earlier.
  - DONE: r/g/b registered from the sector mapping; out_valid=1. Hold r/g/b and out_valid stable until out_ready; then go to IDLE. in_ready stays 0 in DONE.
- Latency: handshake accepted in cycle N; out_valid first high in cycle N+6. Minimum throughput is one pixel per 7 cycles with out_ready tied high.
- Back-to-back operation: a new pixel is accepted at the earliest in the cycle after the DONE handshake, because in_ready is registered.
- Input changes while busy are ignored.
- The multiplier is 8x8 -> 16 unsigned. All intermediate subtractions are on 8-bit values and cannot underflow, because sf, sg <= 255.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, MUL_P=1, MUL_SF=2, MUL_SG=3, MUL_Q=4, MUL_T=5, DONE=6
  - constants HUE_SECTOR_SIZE=256 and HUE_MAX=1536
  - the Div255 function
- One sub-module: mul8x8_u (combinational 8x8 unsigned multiply, 16-bit product), instantiated once and muxed by state.

Test Plan:
- Reset: after reset release, in_ready=1, out_valid=0 and r=g=b=0.
- h=0, s=255, v=255 -> out_valid 6 cycles after accept; (r,g,b)=(255,0,0).
- h=128, s=255, v=255 -> (255,128,0).
- h=512, s=255, v=200 -> (0,200,0).
- s=0, v=77, h in {0, 700, 1535} -> (77,77,77) for each value.
- Hue wrap: h=1600 -> treated as h=64 -> (255,64,0) for s=255, v=255.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises. r/g/b and out_valid must stay stable and in_ready stay 0. Raise out_ready: in_ready=1 on the next cycle.
- Reset mid-operation: assert rst in state MUL_Q. The next cycle shows IDLE state and out_valid=0. No stale output appears.
- Random: 10k random (h,s,v) with random out_ready, checked against a floating-point reference model to within ±1 LSB. The Div255 integer model must match exactly.
